// File: rtl/bigadd_pipe.sv
// bigadd_pipe: wide adder split into NSLICE carry-chained slices, one slice per stage, with a sync strobe aligned to o_r.
// Latency NSLICE clocks; accepts one operand pair every clock and never stalls. Optional BIGADD_FLAGS_EN adds o_carry/o_ovfl.
module bigadd_pipe #(
  parameter int DW     = 64,
  parameter int NSLICE = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_sync,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_r,
  output logic          o_sync
`ifdef BIGADD_FLAGS_EN
  ,
  output logic          o_carry,
  output logic          o_ovfl
`endif
);

  localparam int SW  = DW / NSLICE;
  localparam int TOP = NSLICE - 1;

  // Operands and sum of each slice at the stage where that slice is added.
  logic [SW-1:0] sl_a  [NSLICE];
  logic [SW-1:0] sl_b  [NSLICE];
  logic [SW-1:0] sl_s  [NSLICE];
  logic          sl_co [NSLICE];
  logic          cq    [NSLICE];
  logic [NSLICE-1:0] sync_q;

  for (genvar j = 0; j < NSLICE; j++) begin : g_slice
    logic          cin;
    logic [SW-1:0] ds [NSLICE-j];

    if (j == 0) begin : g_direct
      assign sl_a[j] = i_a[SW-1:0];
      assign sl_b[j] = i_b[SW-1:0];
      assign cin     = 1'b0;
    end else begin : g_skew
      logic [SW-1:0] a_sk [j];
      logic [SW-1:0] b_sk [j];

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          for (int s = 0; s < j; s++) begin
            a_sk[s] <= '0;
            b_sk[s] <= '0;
          end
        end else begin
          a_sk[0] <= i_a[j*SW +: SW];
          b_sk[0] <= i_b[j*SW +: SW];
          for (int s = 1; s < j; s++) begin
            a_sk[s] <= a_sk[s-1];
            b_sk[s] <= b_sk[s-1];
          end
        end
      end

      assign sl_a[j] = a_sk[j-1];
      assign sl_b[j] = b_sk[j-1];
      assign cin     = cq[j-1];
    end

    assign {sl_co[j], sl_s[j]} = {1'b0, sl_a[j]} + {1'b0, sl_b[j]} + {{SW{1'b0}}, cin};

    // Lower slices finish early and wait here so every slice reaches o_r together.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        for (int k = 0; k < NSLICE-j; k++) ds[k] <= '0;
      end else begin
        ds[0] <= sl_s[j];
        for (int k = 1; k < NSLICE-j; k++) ds[k] <= ds[k-1];
      end
    end

    assign o_r[j*SW +: SW] = ds[NSLICE-j-1];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int j = 0; j < NSLICE; j++) cq[j] <= 1'b0;
      sync_q <= '0;
    end else begin
      for (int j = 0; j < NSLICE-1; j++) cq[j] <= sl_co[j];
      sync_q <= NSLICE'({sync_q, i_sync});
    end
  end

  assign o_sync = sync_q[TOP];

`ifdef BIGADD_FLAGS_EN
  logic carry_q;
  logic ovfl_q;

  // Top slice carries the operand sign bits, so flags resolve in the final stage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      carry_q <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      carry_q <= sl_co[TOP];
      ovfl_q  <= (sl_a[TOP][SW-1] == sl_b[TOP][SW-1]) && (sl_s[TOP][SW-1] != sl_a[TOP][SW-1]);
    end
  end

  assign o_carry = carry_q;
  assign o_ovfl  = ovfl_q;
`endif

endmodule

// File: tb/tb_bigadd_pipe.sv
// Bench for bigadd_pipe: NSLICE=2 and NSLICE=4 instances share stimulus and are checked against a whole-word arithmetic model.
module tb_bigadd_pipe;
  localparam int HMAX = 4096;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_sync;
  logic [63:0] i_a;
  logic [63:0] i_b;
  logic [63:0] r2, r4;
  logic        sync2, sync4;
`ifdef BIGADD_FLAGS_EN
  logic        carry2, ovfl2, carry4, ovfl4;
`endif

  always #5 i_clk = ~i_clk;

  bigadd_pipe #(.DW(64), .NSLICE(2)) u_dut2 (
    .i_clk(i_clk), .i_reset(i_reset), .i_sync(i_sync), .i_a(i_a), .i_b(i_b),
    .o_r(r2), .o_sync(sync2)
`ifdef BIGADD_FLAGS_EN
    , .o_carry(carry2), .o_ovfl(ovfl2)
`endif
  );

  bigadd_pipe #(.DW(64), .NSLICE(4)) u_dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_sync(i_sync), .i_a(i_a), .i_b(i_b),
    .o_r(r4), .o_sync(sync4)
`ifdef BIGADD_FLAGS_EN
    , .o_carry(carry4), .o_ovfl(ovfl4)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // History of operands accepted per cycle; zeroed entries stand for discarded data.
  logic [63:0] ha [HMAX];
  logic [63:0] hb [HMAX];
  logic        hs [HMAX];

  task automatic tick();
    @(posedge i_clk);
    cyc++;
    #1;
  endtask

  task automatic put(input logic [63:0] a, input logic [63:0] b, input logic s, input bit keep);
    i_a = a;
    i_b = b;
    i_sync = s;
    ha[cyc] = keep ? a : 64'd0;
    hb[cyc] = keep ? b : 64'd0;
    hs[cyc] = keep ? s : 1'b0;
  endtask

  task automatic flush();
    for (int k = 0; k <= cyc; k++) begin
      ha[k] = '0;
      hb[k] = '0;
      hs[k] = 1'b0;
    end
  endtask

  function automatic logic [63:0] m_r(input int lat);
    int k = cyc - lat;
    if (k < 0) return '0;
    return ha[k] + hb[k];
  endfunction

  function automatic logic m_sync(input int lat);
    int k = cyc - lat;
    if (k < 0) return 1'b0;
    return hs[k];
  endfunction

`ifdef BIGADD_FLAGS_EN
  function automatic logic m_carry(input int lat);
    int k = cyc - lat;
    logic [64:0] t;
    if (k < 0) return 1'b0;
    t = {1'b0, ha[k]} + {1'b0, hb[k]};
    return t[64];
  endfunction

  function automatic logic m_ovfl(input int lat);
    int k = cyc - lat;
    logic [63:0] s;
    if (k < 0) return 1'b0;
    s = ha[k] + hb[k];
    return (ha[k][63] == hb[k][63]) && (s[63] != ha[k][63]);
  endfunction
`endif

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v;
  endfunction

  task automatic test_reset();
    i_reset = 1'b0; i_sync = 1'b0; i_a = '0; i_b = '0;
    #1 i_reset = 1'b1;
    #2;
    tests++; if (r2 !== 64'd0) begin fails++; $display("FAIL reset_r2 got=%h exp=0", r2); end
    tests++; if (sync2 !== 1'b0) begin fails++; $display("FAIL reset_sync2 got=%b exp=0", sync2); end
    tests++; if (r4 !== 64'd0) begin fails++; $display("FAIL reset_r4 got=%h exp=0", r4); end
    tests++; if (sync4 !== 1'b0) begin fails++; $display("FAIL reset_sync4 got=%b exp=0", sync4); end
`ifdef BIGADD_FLAGS_EN
    tests++; if ({carry2, ovfl2, carry4, ovfl4} !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {carry2, ovfl2, carry4, ovfl4}); end
`endif
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    tests++; if (r2 !== 64'd0 || sync2 !== 1'b0) begin fails++; $display("FAIL post_reset2 got=%h/%b exp=0/0", r2, sync2); end
    tests++; if (r4 !== 64'd0 || sync4 !== 1'b0) begin fails++; $display("FAIL post_reset4 got=%h/%b exp=0/0", r4, sync4); end
  endtask

  task automatic test_directed();
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [63:0] er [4];
    logic        ec [4];
    logic        ev [4];
    int rel;
    va = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    vb = '{64'd1, 64'd1, 64'd1, 64'h8000_0000_0000_0000};
    er = '{64'h0000_0001_0000_0000, 64'd0, 64'h8000_0000_0000_0000, 64'd0};
    ec = '{1'b0, 1'b1, 1'b0, 1'b1};
    ev = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      if (i < 4) put(va[i], vb[i], i == 0, 1'b1);
      else       put(64'd0, 64'd0, 1'b0, 1'b1);
      tick();
      rel = i + 1;
      tests++; if (sync2 !== (rel == 2)) begin fails++; $display("FAIL dir_sync2 rel=%0d got=%b exp=%b", rel, sync2, rel == 2); end
      tests++; if (r2 !== m_r(2)) begin fails++; $display("FAIL dir_model_r2 rel=%0d got=%h exp=%h", rel, r2, m_r(2)); end
      if (rel >= 2 && rel <= 5) begin
        tests++; if (r2 !== er[rel-2]) begin fails++; $display("FAIL dir_r2 rel=%0d got=%h exp=%h", rel, r2, er[rel-2]); end
`ifdef BIGADD_FLAGS_EN
        tests++; if (carry2 !== ec[rel-2]) begin fails++; $display("FAIL dir_carry2 rel=%0d got=%b exp=%b", rel, carry2, ec[rel-2]); end
        tests++; if (ovfl2 !== ev[rel-2]) begin fails++; $display("FAIL dir_ovfl2 rel=%0d got=%b exp=%b", rel, ovfl2, ev[rel-2]); end
`endif
      end
    end
  endtask

  task automatic test_slice4();
    int rel;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) put(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1);
      else        put(64'd0, 64'd0, 1'b0, 1'b1);
      tick();
      rel = i + 1;
      tests++; if (sync4 !== (rel == 4)) begin fails++; $display("FAIL s4_sync rel=%0d got=%b exp=%b", rel, sync4, rel == 4); end
      tests++; if (r4 !== m_r(4)) begin fails++; $display("FAIL s4_r rel=%0d got=%h exp=%h", rel, r4, m_r(4)); end
`ifdef BIGADD_FLAGS_EN
      tests++; if (carry4 !== (rel == 4) || ovfl4 !== 1'b0) begin fails++; $display("FAIL s4_flags rel=%0d got=%b%b exp=%b0", rel, carry4, ovfl4, rel == 4); end
`endif
    end
  endtask

  task automatic test_streaming();
    logic [63:0] a, b;
    logic        s, es2;
    int rel;
    for (int i = 0; i < 1000; i++) begin
      a = rnd64();
      b = rnd64();
      case ($urandom_range(0, 3))
        0: begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'($urandom_range(1, 3)); end
        1: a[47:0] = '1;
        default: ;
      endcase
      s = (i == 5) || (i == 6) || (i == 40);
      put(a, b, s, 1'b1);
      tick();
      rel = i + 1;
      es2 = (rel == 7) || (rel == 8) || (rel == 42);
      tests++; if (r2 !== m_r(2)) begin fails++; $display("FAIL str_r2 rel=%0d got=%h exp=%h", rel, r2, m_r(2)); end
      tests++; if (sync2 !== es2) begin fails++; $display("FAIL str_sync2 rel=%0d got=%b exp=%b", rel, sync2, es2); end
      tests++; if (r4 !== m_r(4)) begin fails++; $display("FAIL str_r4 rel=%0d got=%h exp=%h", rel, r4, m_r(4)); end
      tests++; if (sync4 !== m_sync(4)) begin fails++; $display("FAIL str_sync4 rel=%0d got=%b exp=%b", rel, sync4, m_sync(4)); end
`ifdef BIGADD_FLAGS_EN
      tests++; if ({carry2, ovfl2} !== {m_carry(2), m_ovfl(2)}) begin fails++; $display("FAIL str_flags2 rel=%0d got=%b%b exp=%b%b", rel, carry2, ovfl2, m_carry(2), m_ovfl(2)); end
      tests++; if ({carry4, ovfl4} !== {m_carry(4), m_ovfl(4)}) begin fails++; $display("FAIL str_flags4 rel=%0d got=%b%b exp=%b%b", rel, carry4, ovfl4, m_carry(4), m_ovfl(4)); end
`endif
    end
  endtask

  task automatic test_reset_midstream();
    logic s;
    int rel;
    for (int i = 0; i < 32; i++) begin
      s = (i == 10) || (i == 25);
      put(rnd64(), rnd64(), s, i != 12);
      if (i == 11) begin
        #4 i_reset = 1'b1;
        flush();
        #1;
        tests++; if (r2 !== 64'd0 || sync2 !== 1'b0) begin fails++; $display("FAIL mid_rst_now2 got=%h/%b exp=0/0", r2, sync2); end
        tests++; if (r4 !== 64'd0 || sync4 !== 1'b0) begin fails++; $display("FAIL mid_rst_now4 got=%h/%b exp=0/0", r4, sync4); end
`ifdef BIGADD_FLAGS_EN
        tests++; if ({carry2, ovfl2, carry4, ovfl4} !== 4'b0) begin fails++; $display("FAIL mid_rst_flags got=%b exp=0000", {carry2, ovfl2, carry4, ovfl4}); end
`endif
      end
      if (i == 13) #4 i_reset = 1'b0;
      tick();
      rel = i + 1;
      tests++; if (sync2 !== (rel == 27)) begin fails++; $display("FAIL mid_sync2 rel=%0d got=%b exp=%b", rel, sync2, rel == 27); end
      tests++; if (sync4 !== (rel == 29)) begin fails++; $display("FAIL mid_sync4 rel=%0d got=%b exp=%b", rel, sync4, rel == 29); end
      tests++; if (r2 !== m_r(2)) begin fails++; $display("FAIL mid_r2 rel=%0d got=%h exp=%h", rel, r2, m_r(2)); end
      tests++; if (r4 !== m_r(4)) begin fails++; $display("FAIL mid_r4 rel=%0d got=%h exp=%h", rel, r4, m_r(4)); end
`ifdef BIGADD_FLAGS_EN
      tests++; if ({carry2, ovfl2} !== {m_carry(2), m_ovfl(2)}) begin fails++; $display("FAIL mid_flags2 rel=%0d got=%b%b exp=%b%b", rel, carry2, ovfl2, m_carry(2), m_ovfl(2)); end
`endif
    end
  endtask

  initial begin
    for (int k = 0; k < HMAX; k++) begin
      ha[k] = '0;
      hb[k] = '0;
      hs[k] = 1'b0;
    end
    test_reset();
    test_directed();
    test_slice4();
    test_streaming();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
